// File: rtl/cus19_pkg.sv
// Shared types and default widths for the CUS19 fetch controller.
package cus19_pkg;

    localparam int PC_W    = 11;
    localparam int INSTR_W = 19;

    // Fetch sequencer states.
    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_t;

    // Next-PC selection for the PC generator.
    typedef enum logic [1:0] {
        PC_HOLD = 2'd0,
        PC_INC  = 2'd1,
        PC_TGT  = 2'd2,
        PC_RST  = 2'd3
    } pc_sel_t;

endpackage

// File: rtl/cus19_fetch_ctrl_if.sv
// Bus bundle between the fetch controller and the loader, instruction memory and ID stage.
//
// Handshakes:
//   loader: a word is written in every cycle where ld_req_in and ld_gnt_out are both 1;
//           ld_gnt_out only follows ld_req_in while loading, otherwise ld_err_out flags it.
//   ID:     instr_out/instr_pc_out form a word whenever instr_valid_out is 1; stall_in acts as
//           not-ready and holds the presented word stable until the cycle after stall_in drops.
interface cus19_fetch_ctrl_if #(
    parameter int PC_Width    = 11,
    parameter int Instr_Width = 19
);
    import cus19_pkg::*;

    logic                   ld_req_in;
    logic [PC_Width-1:0]    ld_addr_in;
    logic [Instr_Width-1:0] ld_data_in;
    logic                   ld_done_in;
    logic                   ld_gnt_out;
    logic                   ld_err_out;
    logic [PC_Width:0]      ld_count_out;
    logic                   stall_in;
    logic                   flush_in;
    logic [PC_Width-1:0]    branch_tgt_in;
    logic                   halt_in;
    logic [PC_Width-1:0]    mem_addr_out;
    logic                   mem_we_out;
    logic [Instr_Width-1:0] mem_wdata_out;
    logic [Instr_Width-1:0] mem_rdata_in;
    logic [Instr_Width-1:0] instr_out;
    logic [PC_Width-1:0]    instr_pc_out;
    logic                   instr_valid_out;
    logic                   halted_out;
    fetch_state_t           dbg_state;

    modport master (
        input  ld_req_in, ld_addr_in, ld_data_in, ld_done_in,
        input  stall_in, flush_in, branch_tgt_in, halt_in, mem_rdata_in,
        output ld_gnt_out, ld_err_out, ld_count_out,
        output mem_addr_out, mem_we_out, mem_wdata_out,
        output instr_out, instr_pc_out, instr_valid_out, halted_out, dbg_state
    );

    modport slave (
        output ld_req_in, ld_addr_in, ld_data_in, ld_done_in,
        output stall_in, flush_in, branch_tgt_in, halt_in, mem_rdata_in,
        input  ld_gnt_out, ld_err_out, ld_count_out,
        input  mem_addr_out, mem_we_out, mem_wdata_out,
        input  instr_out, instr_pc_out, instr_valid_out, halted_out, dbg_state
    );

endinterface

// File: rtl/cus19_pc_gen.sv
// Program counter register with hold / increment / redirect / reset-vector selection.
module cus19_pc_gen
    import cus19_pkg::*;
#(
    parameter int                  PC_Width = PC_W,
    parameter logic [PC_Width-1:0] RESET_PC = '0
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  pc_sel_t             sel,
    input  logic [PC_Width-1:0] tgt,
    output logic [PC_Width-1:0] pc
);

    logic [PC_Width-1:0] pc_q;
    logic [PC_Width-1:0] pc_d;

    // Next-PC mux; the increment drops its carry so the all-ones address wraps to zero.
    always_comb begin
        pc_d = pc_q;
        case (sel)
            PC_INC:  pc_d = pc_q + 1'b1;
            PC_TGT:  pc_d = tgt;
            PC_RST:  pc_d = RESET_PC;
            default: pc_d = pc_q;
        endcase
    end

    // PC register.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/cus19_fetch_ctrl.sv
// IF-stage sequencer: owns the single-port instruction memory, muxing loader writes during
// boot and PC-driven reads while running, and presents fetched words to ID.
module cus19_fetch_ctrl
    import cus19_pkg::*;
#(
    parameter int PC_Width    = PC_W,
    parameter int Instr_Width = INSTR_W,
    parameter int RESET_PC    = 0
) (
    input  logic               clk_in,
    input  logic               rst_in,
    cus19_fetch_ctrl_if.master bus
);

    localparam logic [PC_Width:0] LD_MAX = {1'b1, {PC_Width{1'b0}}};

    fetch_state_t           state_q;
    fetch_state_t           state_d;
    pc_sel_t                pc_sel;
    logic [PC_Width-1:0]    pc;
    logic [PC_Width-1:0]    iss_pc_q;
    logic                   iss_v_q;
    logic                   issue_en;
    logic                   issue_kill;
    logic                   hold_en;
    logic                   hold_v_q;
    logic [Instr_Width-1:0] hold_q;
    logic [PC_Width:0]      ld_count_q;
    logic                   grant;

    cus19_pc_gen #(
        .PC_Width (PC_Width),
        .RESET_PC (PC_Width'(RESET_PC))
    ) u_pc_gen (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .sel    (pc_sel),
        .tgt    (bus.branch_tgt_in),
        .pc     (pc)
    );

    // State register.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= ST_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and fetch control; halt beats flush, flush beats stall, stall beats advance.
    always_comb begin
        state_d    = state_q;
        pc_sel     = PC_HOLD;
        issue_en   = 1'b0;
        issue_kill = 1'b0;
        hold_en    = 1'b0;
        case (state_q)
            ST_LOAD: begin
                pc_sel = PC_RST;
                if (bus.ld_done_in) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.halt_in) begin
                    state_d    = ST_HALT;
                    issue_kill = 1'b1;
                end else if (bus.flush_in) begin
                    pc_sel     = PC_TGT;
                    issue_kill = 1'b1;
                end else if (bus.stall_in) begin
                    hold_en = 1'b1;
                end else begin
                    pc_sel   = PC_INC;
                    issue_en = 1'b1;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    // Issue register: tags the word the memory returns this cycle with its address.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            iss_pc_q <= '0;
            iss_v_q  <= 1'b0;
        end else if (issue_kill) begin
            iss_v_q <= 1'b0;
        end else if (issue_en) begin
            iss_pc_q <= pc;
            iss_v_q  <= 1'b1;
        end
    end

    // Stall capture: the memory keeps reading pc (one ahead of the presented word) during a
    // stall, so the presented word is frozen here until fetch advances again.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            hold_v_q <= 1'b0;
            hold_q   <= '0;
        end else begin
            hold_v_q <= hold_en;
            if (hold_en && !hold_v_q) begin
                hold_q <= bus.mem_rdata_in;
            end
        end
    end

    assign grant = rst_in && (state_q == ST_LOAD) && bus.ld_req_in;

    // Loader write counter, saturating at the memory depth.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            ld_count_q <= '0;
        end else if (grant && (ld_count_q != LD_MAX)) begin
            ld_count_q <= ld_count_q + 1'b1;
        end
    end

    // Output mux: loader owns the memory port in LOAD, the PC owns it otherwise.
    always_comb begin
        bus.ld_gnt_out      = 1'b0;
        bus.ld_err_out      = 1'b0;
        bus.mem_addr_out    = '0;
        bus.mem_we_out      = 1'b0;
        bus.mem_wdata_out   = '0;
        bus.instr_out       = '0;
        bus.instr_pc_out    = '0;
        bus.instr_valid_out = 1'b0;
        bus.halted_out      = 1'b0;
        if (rst_in) begin
            case (state_q)
                ST_LOAD: begin
                    bus.ld_gnt_out    = bus.ld_req_in;
                    bus.mem_we_out    = bus.ld_req_in;
                    bus.mem_addr_out  = bus.ld_addr_in;
                    bus.mem_wdata_out = bus.ld_data_in;
                end
                ST_RUN: begin
                    bus.ld_err_out      = bus.ld_req_in;
                    bus.mem_addr_out    = pc;
                    bus.instr_out       = hold_v_q ? hold_q : bus.mem_rdata_in;
                    bus.instr_pc_out    = iss_pc_q;
                    bus.instr_valid_out = iss_v_q && !bus.flush_in;
                end
                ST_HALT: begin
                    bus.ld_err_out   = bus.ld_req_in;
                    bus.mem_addr_out = pc;
                    bus.halted_out   = 1'b1;
                end
                default: begin
                    bus.ld_err_out = 1'b0;
                end
            endcase
        end
    end

    assign bus.ld_count_out = ld_count_q;
    assign bus.dbg_state    = state_q;

endmodule

// File: tb/tb_cus19_fetch_ctrl.sv
// Directed bench for cus19_fetch_ctrl: load, run table, stall/flush/halt, reset, wrap and saturation.
module tb_cus19_fetch_ctrl;
    import cus19_pkg::*;

    localparam int PW    = 11;
    localparam int IW    = 19;
    localparam int DEPTH = 2048;

    typedef struct {
        logic          stall;
        logic          flush;
        logic          halt;
        logic          ld_req;
        logic [PW-1:0] tgt;
        logic          exp_valid;
        logic [PW-1:0] exp_pc;
        logic [PW-1:0] exp_addr;
        logic          exp_err;
        logic          exp_halted;
    } vec_t;

    logic clk_in = 1'b0;
    logic rst_in;
    int   checks = 0;
    int   errors = 0;

    logic [IW-1:0] mem1 [DEPTH];
    logic [IW-1:0] mem2 [DEPTH];
    vec_t          vecs [28];

    cus19_fetch_ctrl_if #(.PC_Width(PW), .Instr_Width(IW)) bus1 ();
    cus19_fetch_ctrl_if #(.PC_Width(PW), .Instr_Width(IW)) bus2 ();

    cus19_fetch_ctrl #(.PC_Width(PW), .Instr_Width(IW), .RESET_PC(0)) dut1 (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus1)
    );

    cus19_fetch_ctrl #(.PC_Width(PW), .Instr_Width(IW), .RESET_PC(32'h7FE)) dut2 (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus2)
    );

    // Clock.
    always #5 clk_in = ~clk_in;

    // Synchronous single-port memories, read-before-write.
    always @(posedge clk_in) begin
        if (bus1.mem_we_out) mem1[bus1.mem_addr_out] <= bus1.mem_wdata_out;
        bus1.mem_rdata_in <= mem1[bus1.mem_addr_out];
        if (bus2.mem_we_out) mem2[bus2.mem_addr_out] <= bus2.mem_wdata_out;
        bus2.mem_rdata_in <= mem2[bus2.mem_addr_out];
    end

    function automatic logic [IW-1:0] init_word(input logic [PW-1:0] a);
        return {8'h3C, a};
    endfunction

    function automatic logic [IW-1:0] load_word(input logic [PW-1:0] a);
        return {8'h5A, a};
    endfunction

    function automatic logic [IW-1:0] word1(input logic [PW-1:0] a);
        return (a < 11'd3) ? load_word(a) : init_word(a);
    endfunction

    function automatic logic [IW-1:0] word2(input logic [PW-1:0] a);
        return {8'hC3, a};
    endfunction

    function automatic vec_t mk(input int s, input int f, input int h, input int r, input int t,
                                input int v, input int p, input int a, input int e, input int hl);
        vec_t x;
        x.stall      = s[0];
        x.flush      = f[0];
        x.halt       = h[0];
        x.ld_req     = r[0];
        x.tgt        = t[PW-1:0];
        x.exp_valid  = v[0];
        x.exp_pc     = p[PW-1:0];
        x.exp_addr   = a[PW-1:0];
        x.exp_err    = e[0];
        x.exp_halted = hl[0];
        return x;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        @(negedge clk_in);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt"},   32'(bus1.ld_gnt_out), 32'd0);
        check({tag, "_err"},   32'(bus1.ld_err_out), 32'd0);
        check({tag, "_count"}, 32'(bus1.ld_count_out), 32'd0);
        check({tag, "_addr"},  32'(bus1.mem_addr_out), 32'd0);
        check({tag, "_we"},    32'(bus1.mem_we_out), 32'd0);
        check({tag, "_wdata"}, 32'(bus1.mem_wdata_out), 32'd0);
        check({tag, "_instr"}, 32'(bus1.instr_out), 32'd0);
        check({tag, "_ipc"},   32'(bus1.instr_pc_out), 32'd0);
        check({tag, "_valid"}, 32'(bus1.instr_valid_out), 32'd0);
        check({tag, "_halted"}, 32'(bus1.halted_out), 32'd0);
        check({tag, "_state"}, 32'(bus1.dbg_state), 32'(ST_LOAD));
    endtask

    task automatic idle_inputs();
        bus1.ld_req_in = 1'b0; bus1.ld_addr_in = '0; bus1.ld_data_in = '0; bus1.ld_done_in = 1'b0;
        bus1.stall_in = 1'b0; bus1.flush_in = 1'b0; bus1.branch_tgt_in = '0; bus1.halt_in = 1'b0;
        bus2.ld_req_in = 1'b0; bus2.ld_addr_in = '0; bus2.ld_data_in = '0; bus2.ld_done_in = 1'b0;
        bus2.stall_in = 1'b0; bus2.flush_in = 1'b0; bus2.branch_tgt_in = '0; bus2.halt_in = 1'b0;
    endtask

    initial begin
        // Vector table for instance 1, one entry per cycle starting right after LOAD exits.
        //               st fl ht rq tgt   v  pc     addr   err hlt
        vecs[0]  = mk(0, 0, 0, 0, 0,    0, 0,     0,     0, 0);
        vecs[1]  = mk(0, 0, 0, 0, 0,    1, 0,     1,     0, 0);
        vecs[2]  = mk(0, 0, 0, 0, 0,    1, 1,     2,     0, 0);
        vecs[3]  = mk(0, 0, 0, 0, 0,    1, 2,     3,     0, 0);
        vecs[4]  = mk(0, 0, 0, 0, 0,    1, 3,     4,     0, 0);
        vecs[5]  = mk(0, 0, 0, 0, 0,    1, 4,     5,     0, 0);
        vecs[6]  = mk(1, 0, 0, 0, 0,    1, 5,     6,     0, 0);
        vecs[7]  = mk(1, 0, 0, 0, 0,    1, 5,     6,     0, 0);
        vecs[8]  = mk(1, 0, 0, 0, 0,    1, 5,     6,     0, 0);
        vecs[9]  = mk(0, 0, 0, 0, 0,    1, 5,     6,     0, 0);
        vecs[10] = mk(0, 0, 0, 0, 0,    1, 6,     7,     0, 0);
        vecs[11] = mk(0, 0, 0, 0, 0,    1, 7,     8,     0, 0);
        vecs[12] = mk(0, 0, 0, 0, 0,    1, 8,     9,     0, 0);
        vecs[13] = mk(0, 0, 0, 0, 0,    1, 9,     10,    0, 0);
        vecs[14] = mk(0, 1, 0, 0, 'h40, 0, 0,     11,    0, 0);
        vecs[15] = mk(0, 0, 0, 0, 0,    0, 0,     'h40,  0, 0);
        vecs[16] = mk(0, 0, 0, 0, 0,    1, 'h40,  'h41,  0, 0);
        vecs[17] = mk(0, 0, 0, 0, 0,    1, 'h41,  'h42,  0, 0);
        vecs[18] = mk(1, 1, 0, 0, 'h20, 0, 0,     'h43,  0, 0);
        vecs[19] = mk(0, 0, 0, 0, 0,    0, 0,     'h20,  0, 0);
        vecs[20] = mk(0, 0, 0, 0, 0,    1, 'h20,  'h21,  0, 0);
        vecs[21] = mk(0, 0, 0, 1, 0,    1, 'h21,  'h22,  1, 0);
        vecs[22] = mk(0, 0, 0, 1, 0,    1, 'h22,  'h23,  1, 0);
        vecs[23] = mk(0, 0, 0, 0, 0,    1, 'h23,  'h24,  0, 0);
        vecs[24] = mk(0, 0, 1, 0, 0,    1, 'h24,  'h25,  0, 0);
        vecs[25] = mk(0, 1, 0, 0, 'h10, 0, 0,     'h25,  0, 1);
        vecs[26] = mk(0, 0, 0, 1, 0,    0, 0,     'h25,  1, 1);
        vecs[27] = mk(0, 0, 0, 0, 0,    0, 0,     'h25,  0, 1);

        for (int a = 0; a < DEPTH; a++) begin
            mem1[a] = init_word(a[PW-1:0]);
            mem2[a] = '0;
        end

        // Reset state.
        rst_in = 1'b0;
        idle_inputs();
        @(negedge clk_in);
        #1;
        check_all_zero("reset");
        rst_in = 1'b1;
        step();

        // Boot load of three words.
        for (int i = 0; i < 3; i++) begin
            bus1.ld_req_in  = 1'b1;
            bus1.ld_addr_in = i[PW-1:0];
            bus1.ld_data_in = load_word(i[PW-1:0]);
            #1;
            check("load_gnt",   32'(bus1.ld_gnt_out), 32'd1);
            check("load_we",    32'(bus1.mem_we_out), 32'd1);
            check("load_addr",  32'(bus1.mem_addr_out), 32'(i));
            check("load_wdata", 32'(bus1.mem_wdata_out), 32'(load_word(i[PW-1:0])));
            check("load_err",   32'(bus1.ld_err_out), 32'd0);
            step();
        end
        bus1.ld_req_in  = 1'b0;
        bus1.ld_done_in = 1'b1;
        #1;
        check("load_count", 32'(bus1.ld_count_out), 32'd3);
        check("load_state", 32'(bus1.dbg_state), 32'(ST_LOAD));
        step();
        bus1.ld_done_in = 1'b0;
        check("run_state", 32'(bus1.dbg_state), 32'(ST_RUN));

        // Table-driven run: fetch order, stall, flush, flush+stall, loader error, halt.
        bus1.ld_addr_in = 11'h21;
        bus1.ld_data_in = 19'h7FFFF;
        for (int i = 0; i < 28; i++) begin
            bus1.stall_in      = vecs[i].stall;
            bus1.flush_in      = vecs[i].flush;
            bus1.halt_in       = vecs[i].halt;
            bus1.ld_req_in     = vecs[i].ld_req;
            bus1.branch_tgt_in = vecs[i].tgt;
            #1;
            check($sformatf("v%0d_valid", i),  32'(bus1.instr_valid_out), 32'(vecs[i].exp_valid));
            check($sformatf("v%0d_addr", i),   32'(bus1.mem_addr_out), 32'(vecs[i].exp_addr));
            check($sformatf("v%0d_err", i),    32'(bus1.ld_err_out), 32'(vecs[i].exp_err));
            check($sformatf("v%0d_halted", i), 32'(bus1.halted_out), 32'(vecs[i].exp_halted));
            check($sformatf("v%0d_we", i),     32'(bus1.mem_we_out), 32'd0);
            check($sformatf("v%0d_gnt", i),    32'(bus1.ld_gnt_out), 32'd0);
            if (vecs[i].exp_valid) begin
                check($sformatf("v%0d_pc", i),    32'(bus1.instr_pc_out), 32'(vecs[i].exp_pc));
                check($sformatf("v%0d_instr", i), 32'(bus1.instr_out), 32'(word1(vecs[i].exp_pc)));
            end
            step();
        end
        idle_inputs();
        check("err_mem_untouched", 32'(mem1[11'h21]), 32'(init_word(11'h21)));
        check("halt_state", 32'(bus1.dbg_state), 32'(ST_HALT));

        // Reset leaves HALT and clears the load count.
        rst_in = 1'b0;
        #1;
        check_all_zero("halt_reset");
        step();
        rst_in = 1'b1;
        step();

        // Reset in the middle of RUN with a word in flight.
        bus1.ld_done_in = 1'b1;
        step();
        bus1.ld_done_in = 1'b0;
        step();
        #1;
        check("midrun_valid", 32'(bus1.instr_valid_out), 32'd1);
        check("midrun_instr", 32'(bus1.instr_out), 32'(word1(11'd0)));
        rst_in = 1'b0;
        #1;
        check_all_zero("midrun_reset");
        step();
        rst_in = 1'b1;
        step();

        // Instance 2: fill the whole memory to reach the count ceiling.
        for (int a = 0; a < DEPTH; a++) begin
            bus2.ld_req_in  = 1'b1;
            bus2.ld_addr_in = a[PW-1:0];
            bus2.ld_data_in = word2(a[PW-1:0]);
            step();
        end
        bus2.ld_req_in = 1'b0;
        #1;
        check("sat_count_full", 32'(bus2.ld_count_out), 32'h800);

        // One more write together with ld_done_in: granted, count stays saturated, then RUN.
        bus2.ld_req_in  = 1'b1;
        bus2.ld_done_in = 1'b1;
        bus2.ld_addr_in = 11'd5;
        bus2.ld_data_in = 19'h12345;
        #1;
        check("sat_gnt", 32'(bus2.ld_gnt_out), 32'd1);
        check("sat_we",  32'(bus2.mem_we_out), 32'd1);
        step();
        idle_inputs();
        check("sat_count_hold", 32'(bus2.ld_count_out), 32'h800);
        check("sat_state", 32'(bus2.dbg_state), 32'(ST_RUN));
        check("sat_mem_written", 32'(mem2[5]), 32'h12345);
        check("wrap_first_addr", 32'(bus2.mem_addr_out), 32'h7FE);
        check("wrap_first_valid", 32'(bus2.instr_valid_out), 32'd0);

        // Fetch order across the top of the address space.
        step();
        check("wrap_v0", 32'(bus2.instr_valid_out), 32'd1);
        check("wrap_pc0", 32'(bus2.instr_pc_out), 32'h7FE);
        check("wrap_i0", 32'(bus2.instr_out), 32'(word2(11'h7FE)));
        step();
        check("wrap_pc1", 32'(bus2.instr_pc_out), 32'h7FF);
        check("wrap_i1", 32'(bus2.instr_out), 32'(word2(11'h7FF)));
        step();
        check("wrap_v2", 32'(bus2.instr_valid_out), 32'd1);
        check("wrap_pc2", 32'(bus2.instr_pc_out), 32'h000);
        check("wrap_i2", 32'(bus2.instr_out), 32'(word2(11'h000)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
